left_shift_unit: RTL and testbench

LEFT_SHIFT_UNIT -- requirements
Module: left_shift_unit

---
 rtl/left_shift_unit.sv | 88 ++++++++
 tb/tb_left_shift_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/left_shift_unit.sv
// Iterative logical left shifter: one log-shift stage per cycle.
// Fixed latency of STAGES cycles from accept to result.
module left_shift_unit #(
    parameter int WIDTH = 32,
    localparam int STAGES = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [STAGES-1:0] shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [STAGES-1:0] stage;
    logic [STAGES-1:0] shamt_q;
    logic [WIDTH-1:0]  data;

    logic take;
    logic last;

    // Stage k applies a shift of 2^k when shamt bit k is set.
    assign take = |(shamt_q & (STAGES'(1) << stage));
    assign last = (stage == STAGES'(STAGES - 1));
    assign out  = data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stage     <= '0;
            shamt_q   <= '0;
            data      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        data     <= a;
                        shamt_q  <= shamt;
                        stage    <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (take)
                        data <= data << (32'd1 << stage);
                    if (last) begin
                        stage     <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        stage <= stage + STAGES'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_left_shift_unit.sv
// Directed bench for left_shift_unit: latency, stall,
// mid-op reset and a back-to-back operand sweep.
module tb_left_shift_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    left_shift_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    task automatic expect_eq(input string tag,
                             input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge where
    // out_valid is expected, plus one more if out_ready is high.
    task automatic run_op(input string tag,
                          input logic [31:0] av,
                          input logic [4:0] sv,
                          input logic [31:0] exp);
        expect_eq({tag, "/in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = av;
        shamt    = sv;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'hA5A5_5A5A;
        shamt    = 5'd31;
        for (int i = 0; i < 5; i++) begin
            expect_eq({tag, "/lat_valid"}, {31'b0, out_valid}, 32'd0);
            expect_eq({tag, "/busy"}, {31'b0, busy}, 32'd1);
            @(negedge clk);
        end
        expect_eq({tag, "/out_valid"}, {31'b0, out_valid}, 32'd1);
        expect_eq({tag, "/out"}, out, exp);
        if (out_ready) begin
            @(negedge clk);
            expect_eq({tag, "/idle_ready"}, {31'b0, in_ready}, 32'd1);
            expect_eq({tag, "/idle_valid"}, {31'b0, out_valid}, 32'd0);
            expect_eq({tag, "/idle_busy"}, {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] av;
        logic [4:0]  sv;
        logic [4:0]  svec [5];
        svec = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b1;
        #1;
        expect_eq("rst/in_ready", {31'b0, in_ready}, 32'd1);
        expect_eq("rst/out_valid", {31'b0, out_valid}, 32'd0);
        expect_eq("rst/out", out, 32'd0);
        expect_eq("rst/busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("msb", 32'h0000_0001, 5'd31, 32'h8000_0000);
        run_op("neg", 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFFA);
        run_op("pos", 32'h0000_0003, 5'd4, 32'h0000_0030);
        run_op("zero", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);

        // Output stall with a competing operand offered.
        out_ready = 1'b0;
        run_op("stall", 32'h0000_FFFF, 5'd16, 32'hFFFF_0000);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = 32'h1111_1111;
            shamt    = 5'd3;
            expect_eq("stall/valid", {31'b0, out_valid}, 32'd1);
            expect_eq("stall/out", out, 32'hFFFF_0000);
            expect_eq("stall/in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        expect_eq("stall/release_ready", {31'b0, in_ready}, 32'd1);
        expect_eq("stall/release_valid", {31'b0, out_valid}, 32'd0);
        expect_eq("stall/release_out", out, 32'hFFFF_0000);

        // Reset after the second SHIFT cycle.
        in_valid = 1'b1;
        a        = 32'h1234_5678;
        shamt    = 5'd8;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_eq("midrst/out", out, 32'd0);
        expect_eq("midrst/out_valid", {31'b0, out_valid}, 32'd0);
        expect_eq("midrst/in_ready", {31'b0, in_ready}, 32'd1);
        expect_eq("midrst/busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("fresh", 32'h0000_0001, 5'd2, 32'h0000_0004);

        // Back-to-back sweep, one result every 7 cycles.
        for (int v = -3; v <= 3; v++) begin
            for (int k = 0; k < 5; k++) begin
                av = 32'(v);
                sv = svec[k];
                run_op("sweep", av, sv, av << sv);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
